// File: rtl/trig_pkg.sv
// Shared types and helpers for the trigger coincidence shaper.
package trig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WINDOW = 2'd1,
    ST_FIRE   = 2'd2,
    ST_DEAD   = 2'd3
  } state_e;

  // Channel vectors are zero-extended to POP_MAXW before counting.
  localparam int POP_MAXW = 32;
  localparam int POPW     = 6;

  function automatic logic [POPW-1:0] popcount(input logic [POP_MAXW-1:0] v);
    logic [POPW-1:0] c;
    c = '0;
    for (int i = 0; i < POP_MAXW; i++) c = c + POPW'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            inc_i,
  input  logic            clr_i,
  output logic [CNTW-1:0] cnt_o
);

  logic [CNTW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                       cnt_q <= '0;
    else if (clr_i)                  cnt_q <= '0;
    else if (inc_i && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/trigger_coincidence_shaper.sv
// N-fold coincidence former: window, shaped trigger pulse, dead time, and
// saturating accept/reject counters.
module trigger_coincidence_shaper
  import trig_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int WINW = 8,
  parameter int CNTW = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     enable,
  input  logic                     cnt_clear,
  input  logic [NCH-1:0]           pulse_in,
  input  logic [NCH-1:0]           chan_mask,
  input  logic [$clog2(NCH+1)-1:0] min_mult,
  input  logic [WINW-1:0]          win_len,
  input  logic [WINW-1:0]          out_width,
  input  logic [WINW-1:0]          dead_len,
  output logic                     trig_out,
  output logic [NCH-1:0]           trig_pattern,
  output logic                     busy,
  output logic [CNTW-1:0]          accept_cnt,
  output logic [CNTW-1:0]          reject_cnt
);

  state_e          state_q, state_d;
  logic [NCH-1:0]  pat_q, pat_d;
  logic [NCH-1:0]  tpat_q, tpat_d;
  logic [WINW-1:0] wcnt_q, wcnt_d;
  logic [WINW-1:0] ocnt_q, ocnt_d;
  logic [WINW-1:0] dcnt_q, dcnt_d;
  logic            trig_q, busy_q;
  logic            acc_inc, rej_inc;

  logic [NCH-1:0]  hits, nxt_pat;
  logic [POPW-1:0] mult, thr;
  logic            go_fire;

  assign hits    = pulse_in & chan_mask;
  assign nxt_pat = pat_q | hits;
  assign mult    = popcount(POP_MAXW'(nxt_pat));
  assign thr     = (min_mult == '0) ? POPW'(1) : POPW'(min_mult);
  // pat_q is empty in IDLE and thr >= 1, so an IDLE fire always implies a hit.
  assign go_fire = enable && (state_q inside {ST_IDLE, ST_WINDOW}) && (mult >= thr);

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    tpat_d  = tpat_q;
    wcnt_d  = wcnt_q;
    ocnt_d  = ocnt_q;
    dcnt_d  = dcnt_q;
    acc_inc = 1'b0;
    rej_inc = 1'b0;
    if (!enable) begin
      state_d = ST_IDLE;
      pat_d   = '0;
    end else if (go_fire) begin
      state_d = ST_FIRE;
      tpat_d  = nxt_pat;
      pat_d   = '0;
      ocnt_d  = (out_width == '0) ? WINW'(1) : out_width;
      acc_inc = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: if (hits != '0) begin
          if (win_len == '0) rej_inc = 1'b1;
          else begin
            state_d = ST_WINDOW;
            pat_d   = hits;
            wcnt_d  = win_len;
          end
        end
        ST_WINDOW: if (wcnt_q <= WINW'(1)) begin
          state_d = ST_IDLE;
          pat_d   = '0;
          rej_inc = 1'b1;
        end else begin
          pat_d  = nxt_pat;
          wcnt_d = wcnt_q - 1'b1;
        end
        ST_FIRE: if (ocnt_q <= WINW'(1)) begin
          // dead_len is sampled as the pulse ends, not when it starts
          state_d = (dead_len == '0) ? ST_IDLE : ST_DEAD;
          dcnt_d  = dead_len;
        end else begin
          ocnt_d = ocnt_q - 1'b1;
        end
        ST_DEAD: if (dcnt_q <= WINW'(1)) state_d = ST_IDLE;
                 else                     dcnt_d  = dcnt_q - 1'b1;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      tpat_q  <= '0;
      wcnt_q  <= '0;
      ocnt_q  <= '0;
      dcnt_q  <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      tpat_q  <= tpat_d;
      wcnt_q  <= wcnt_d;
      ocnt_q  <= ocnt_d;
      dcnt_q  <= dcnt_d;
      trig_q  <= (state_d == ST_FIRE);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  sat_counter #(.CNTW(CNTW)) u_acc (
    .clk  (clk),
    .rstn (rstn),
    .inc_i(acc_inc),
    .clr_i(cnt_clear),
    .cnt_o(accept_cnt)
  );

  sat_counter #(.CNTW(CNTW)) u_rej (
    .clk  (clk),
    .rstn (rstn),
    .inc_i(rej_inc),
    .clr_i(cnt_clear),
    .cnt_o(reject_cnt)
  );

  assign trig_out     = trig_q;
  assign trig_pattern = tpat_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_trigger_coincidence_shaper.sv
// Randomised + directed bench against a timestamp-based reference model.
module tb_trigger_coincidence_shaper;
  localparam int NCH  = 4;
  localparam int WINW = 8;
  localparam int CNTW = 16;
  localparam int MW   = $clog2(NCH+1);

  logic            clk = 1'b0, rstn = 1'b0, enable = 1'b0, cnt_clear = 1'b0;
  logic [NCH-1:0]  pulse_in = '0, chan_mask = '0;
  logic [MW-1:0]   min_mult = '0;
  logic [WINW-1:0] win_len = '0, out_width = '0, dead_len = '0;
  logic            trig_out, busy;
  logic [NCH-1:0]  trig_pattern;
  logic [CNTW-1:0] accept_cnt, reject_cnt;
  // narrow-counter copy, used to reach saturation cheaply
  logic            s_trig, s_busy;
  logic [NCH-1:0]  s_pat;
  logic [3:0]      s_acc, s_rej;

  always #5 clk = ~clk;

  trigger_coincidence_shaper #(.NCH(NCH), .WINW(WINW), .CNTW(CNTW)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .cnt_clear(cnt_clear),
    .pulse_in(pulse_in), .chan_mask(chan_mask), .min_mult(min_mult),
    .win_len(win_len), .out_width(out_width), .dead_len(dead_len),
    .trig_out(trig_out), .trig_pattern(trig_pattern), .busy(busy),
    .accept_cnt(accept_cnt), .reject_cnt(reject_cnt));

  trigger_coincidence_shaper #(.NCH(NCH), .WINW(WINW), .CNTW(4)) dut_s (
    .clk(clk), .rstn(rstn), .enable(enable), .cnt_clear(cnt_clear),
    .pulse_in(pulse_in), .chan_mask(chan_mask), .min_mult(min_mult),
    .win_len(win_len), .out_width(out_width), .dead_len(dead_len),
    .trig_out(s_trig), .trig_pattern(s_pat), .busy(s_busy),
    .accept_cnt(s_acc), .reject_cnt(s_rej));

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: every phase is an absolute cycle stamp.
  int             n;
  bit             m_open;
  int             m_wlast, m_flast, m_dlast;
  logic [NCH-1:0] m_pat, m_tpat;
  int             m_acc, m_rej, m_sacc, m_srej;

  task automatic model_reset();
    m_open = 0; m_wlast = -1; m_flast = -1; m_dlast = -1;
    m_pat = '0; m_tpat = '0;
    m_acc = 0; m_rej = 0; m_sacc = 0; m_srej = 0;
  endtask

  task automatic bump_rej();
    if (m_rej  < 65535) m_rej++;
    if (m_srej < 15)    m_srej++;
  endtask

  task automatic model_step();
    logic [NCH-1:0] h, np;
    int thr;
    h   = pulse_in & chan_mask;
    thr = (min_mult == 0) ? 1 : int'(min_mult);
    if (!enable) begin
      m_open = 0; m_pat = '0; m_flast = -1; m_dlast = -1;
    end else if (n <= m_flast) begin
      if (n == m_flast) m_dlast = n + int'(dead_len);
    end else if (n <= m_dlast) begin
      // dead time: pulses dropped
    end else begin
      np = (m_open ? m_pat : '0) | h;
      if ($countones(np) >= thr) begin
        m_tpat  = np;
        m_flast = n + ((out_width == 0) ? 1 : int'(out_width));
        m_dlast = -1;
        m_open  = 0;
        m_pat   = '0;
        if (m_acc  < 65535) m_acc++;
        if (m_sacc < 15)    m_sacc++;
      end else if (m_open) begin
        m_pat = np;
        if (n == m_wlast) begin
          m_open = 0; m_pat = '0; bump_rej();
        end
      end else if (h != '0) begin
        if (win_len == 0) bump_rej();
        else begin
          m_open = 1; m_wlast = n + int'(win_len); m_pat = h;
        end
      end
    end
    if (cnt_clear) begin
      m_acc = 0; m_rej = 0; m_sacc = 0; m_srej = 0;
    end
    n++;
  endtask

  task automatic check_all();
    chk("trig_out",     32'(trig_out),     32'(n <= m_flast));
    chk("busy",         32'(busy),         32'(m_open || n <= m_flast || n <= m_dlast));
    chk("trig_pattern", 32'(trig_pattern), 32'(m_tpat));
    chk("accept_cnt",   32'(accept_cnt),   32'(m_acc));
    chk("reject_cnt",   32'(reject_cnt),   32'(m_rej));
    chk("s_accept_cnt", 32'(s_acc),        32'(m_sacc));
    chk("s_reject_cnt", 32'(s_rej),        32'(m_srej));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic cfg(input logic [NCH-1:0] mask, input int mm, input int wl,
                     input int ow, input int dl);
    chan_mask = mask; min_mult = MW'(mm);
    win_len = WINW'(wl); out_width = WINW'(ow); dead_len = WINW'(dl);
  endtask

  task automatic idle(input int k);
    pulse_in = '0;
    for (int i = 0; i < k; i++) cyc();
  endtask

  initial begin
    n = 0;
    model_reset();
    #12;
    chk("rst_trig", 32'(trig_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_pat",  32'(trig_pattern), 0);
    chk("rst_acc",  32'(accept_cnt), 0);
    chk("rst_rej",  32'(reject_cnt), 0);
    rstn = 1'b1; enable = 1'b1;

    // two-fold coincidence inside a 3-cycle window
    cfg(4'b1111, 2, 3, 2, 2);
    pulse_in = 4'b0001; cyc();
    pulse_in = 4'b0000; cyc();
    pulse_in = 4'b0100; cyc();
    pulse_in = 4'b0000;
    chk("t1_trig", 32'(trig_out), 1);
    chk("t1_pat",  32'(trig_pattern), 32'h5);
    chk("t1_acc",  32'(accept_cnt), 1);
    idle(8);

    // repeated channel does not reach threefold
    cfg(4'b1111, 3, 3, 2, 2);
    pulse_in = 4'b0001; cyc();
    pulse_in = 4'b0001; cyc();
    idle(2);
    chk("t2_busy", 32'(busy), 0);
    chk("t2_rej",  32'(reject_cnt), 1);
    chk("t2_trig", 32'(trig_out), 0);
    idle(3);

    // single-fold with width 4 and dead time 5, continuous ch3 afterwards
    cfg(4'b1111, 1, 3, 4, 5);
    pulse_in = 4'b0010; cyc();
    pulse_in = 4'b1000;
    for (int i = 0; i < 12; i++) cyc();
    idle(12);

    // masked-out channels: never fires, every window is a reject
    cfg(4'b0001, 2, 2, 2, 2);
    pulse_in = 4'b1111;
    for (int i = 0; i < 60; i++) cyc();
    chk("t4_srej_sat", 32'(s_rej), 32'hF);
    idle(4);

    // enable drop during a long trigger pulse
    cfg(4'b1111, 1, 3, 10, 2);
    pulse_in = 4'b0001; cyc();
    idle(3);
    enable = 1'b0; cyc();
    chk("t5_trig_off", 32'(trig_out), 0);
    chk("t5_busy_off", 32'(busy), 0);
    enable = 1'b1;
    idle(3);

    // async reset in the middle of a window
    cfg(4'b1111, 4, 10, 2, 2);
    pulse_in = 4'b0001; cyc();
    idle(2);
    #2 rstn = 1'b0;
    #1;
    chk("t5_arst_trig", 32'(trig_out), 0);
    chk("t5_arst_busy", 32'(busy), 0);
    chk("t5_arst_pat",  32'(trig_pattern), 0);
    chk("t5_arst_acc",  32'(accept_cnt), 0);
    chk("t5_arst_rej",  32'(reject_cnt), 0);
    model_reset();
    @(posedge clk); #1 rstn = 1'b1;
    idle(3);

    // back-to-back fires saturate the narrow counter, then clear vs fire
    cfg(4'b1111, 1, 3, 1, 0);
    pulse_in = 4'b0001;
    for (int i = 0; i < 40; i++) cyc();
    chk("t6_sacc_sat", 32'(s_acc), 32'hF);
    idle(3);
    pulse_in = 4'b0001; cnt_clear = 1'b1; cyc();
    cnt_clear = 1'b0; pulse_in = '0;
    chk("t6_clr_acc",  32'(accept_cnt), 0);
    chk("t6_clr_trig", 32'(trig_out), 1);
    idle(3);

    // randomised traffic with live control changes
    for (int i = 0; i < 4000; i++) begin
      if ((i % 50) == 0)
        cfg(NCH'($urandom), $urandom_range(0, NCH), $urandom_range(0, 6),
            $urandom_range(0, 4), $urandom_range(0, 4));
      else if ($urandom_range(0, 99) < 3)
        cfg(chan_mask, $urandom_range(0, NCH), $urandom_range(0, 6),
            $urandom_range(0, 4), $urandom_range(0, 4));
      for (int c = 0; c < NCH; c++) pulse_in[c] = ($urandom_range(0, 99) < 15);
      enable    = ($urandom_range(0, 99) < 97);
      cnt_clear = ($urandom_range(0, 999) < 5);
      cyc();
    end
    enable = 1'b1; cnt_clear = 1'b0;
    idle(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
